hsmc_link_rx: RTL and testbench

- Receive end of the board-to-board HSMC parallel link; the HSMC_TX_p lanes carry the transmit direction.
- Samples 17 HSMC receive lanes asynchronously: lanes [15:0] are data, lane [16] is a toggle strobe.
- Synchronises the lanes, decodes framed packets, verifies the checksum and delivers the payload over a ready/valid stream through an internal FIFO.
- Sits between the top-level HSMC pins and fabric consumers.

---
 rtl/hsmc_link_rx_if.sv | 20 ++
 rtl/hsmc_link_rx.sv | 254 +++++++++++++++++++++++++
 tb/tb_hsmc_link_rx.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hsmc_link_rx_if.sv
// -----------------------------------------------------------------------------
// hsmc_link_rx_if
// Ready/valid payload stream leaving the HSMC receive block.
//
//   rx_data  [15:0]  payload word at the FIFO head
//   rx_valid         head word present
//   rx_last          head word is the final payload word of its frame
//   rx_ready         consumer accepts the head word this cycle
//
// Modports: master = producer (hsmc_link_rx), slave = fabric consumer.
// -----------------------------------------------------------------------------
interface hsmc_link_rx_if;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_last;
    logic        rx_ready;

    modport master (output rx_data, output rx_valid, output rx_last, input rx_ready);
    modport slave  (input rx_data, input rx_valid, input rx_last, output rx_ready);
endinterface

// File: rtl/hsmc_link_rx.sv
// -----------------------------------------------------------------------------
// hsmc_link_rx
// Receive end of the board-to-board HSMC parallel link. The 17 asynchronous
// lanes are synchronised, lane 16 is a toggle strobe marking each new word,
// words are framed as {8'hA5, LEN}, LEN payload words, 16-bit sum checksum.
// Payload goes out through a registered-head FIFO on a ready/valid stream.
//
// Ports:
//   OSC_50_B8A    in   50 MHz clock, all logic on the rising edge
//   RESET         in   synchronous active-high reset
//   hsmc_rx[16:0] in   raw lanes: [16] strobe, [15:0] data
//   rx            master modport of hsmc_link_rx_if (data/valid/last/ready)
//   frame_ok      out  1-cycle pulse: frame complete, checksum good, no drops
//   frame_err     out  1-cycle pulse: bad header, bad checksum, drop, timeout
//   overflow      out  sticky: a payload word was dropped on a full FIFO
//   clr_overflow  in   clears overflow (a new drop on the same cycle wins)
//
// Optional feature: define HSMC_RX_TIMEOUT_EN to abort a frame after TIMEOUT
// cycles without a strobe event while in PAYLOAD or CHECK.
// -----------------------------------------------------------------------------
module hsmc_link_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 2,
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT     = 4096
) (
    input  logic                  OSC_50_B8A,
    input  logic                  RESET,
    input  logic [16:0]           hsmc_rx,
    hsmc_link_rx_if.master        rx,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    if (SYNC_STAGES < 2 || SETTLE < 1 || FIFO_DEPTH < 4 || FIFO_DEPTH > 256 ||
        (1 << AW) != FIFO_DEPTH || TIMEOUT < 2) begin : g_param_check
        $error("hsmc_link_rx: illegal parameter combination");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_CHECK} state_e;

    // ---------------- registers and next-state ----------------
    logic [SYNC_STAGES-1:0][16:0] sync_q, sync_d;
    logic                         strobe_q;
    logic                         busy_q, busy_d;
    logic [SW-1:0]                cnt_q, cnt_d;
    logic                         word_vld_q, word_vld_d;
    logic [15:0]                  word_q, word_d;

    state_e                       state_q, state_d;
    logic [7:0]                   rem_q, rem_d;
    logic [15:0]                  csum_q, csum_d;
    logic                         drop_q, drop_d;
    logic                         ok_q, ok_d, err_q, err_d;

    logic [16:0]                  mem [FIFO_DEPTH];
    logic [AW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]                  count_q, count_d, count_after_pop;
    logic                         out_valid_q, out_valid_d;
    logic [16:0]                  out_q, out_d;
    logic                         overflow_q, overflow_d;

    logic [16:0] sync_w;
    logic        evt;
    logic        push, push_last, push_acc, push_drop, pop, fifo_full;

`ifdef HSMC_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_fire;
`endif

    // ---------------- synchroniser and word capture ----------------
    assign sync_d = {sync_q[SYNC_STAGES-2:0], hsmc_rx};
    assign sync_w = sync_q[SYNC_STAGES-1];
    assign evt    = sync_w[16] ^ strobe_q;

    // The strobe history follows the synchroniser every cycle, so events that
    // land inside the settle window are consumed without starting a capture.
    always_comb begin : capture_comb
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise a latch is inferred.
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        word_vld_d = 1'b0;
        word_d     = word_q;
        if (busy_q) begin
            if (cnt_q == SW'(1)) begin
                busy_d     = 1'b0;
                word_vld_d = 1'b1;
                word_d     = sync_w[15:0];
            end else begin
                cnt_d = cnt_q - SW'(1);
            end
        end else if (evt) begin
            busy_d = 1'b1;
            cnt_d  = SW'(SETTLE);
        end
    end

`ifdef HSMC_RX_TIMEOUT_EN
    // Counts idle cycles since the last strobe event while a frame is open.
    always_comb begin : timeout_comb
        tmo_d    = (state_q == ST_IDLE || evt) ? '0 : tmo_q + TW'(1);
        tmo_fire = (state_q != ST_IDLE) && !evt && (tmo_d == TW'(TIMEOUT));
    end
`endif

    // ---------------- frame state machine ----------------
    always_comb begin : fsm_comb
        state_d   = state_q;
        rem_d     = rem_q;
        csum_d    = csum_q;
        drop_d    = drop_q;
        push      = 1'b0;
        push_last = 1'b0;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (word_vld_q) begin
                    if (word_q[15:8] == 8'hA5 && word_q[7:0] != 8'd0) begin
                        rem_d   = word_q[7:0];
                        csum_d  = '0;
                        drop_d  = 1'b0;
                        state_d = ST_PAYLOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (word_vld_q) begin
                    push      = 1'b1;
                    push_last = (rem_q == 8'd1);
                    csum_d    = csum_q + word_q;
                    rem_d     = rem_q - 8'd1;
                    if (fifo_full && !pop) drop_d = 1'b1;
                    if (rem_q == 8'd1) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (word_vld_q) begin
                    if (word_q == csum_q && !drop_q) ok_d  = 1'b1;
                    else                             err_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef HSMC_RX_TIMEOUT_EN
        // Abort takes precedence over a word captured on the same cycle.
        if (tmo_fire) begin
            state_d   = ST_IDLE;
            push      = 1'b0;
            push_last = 1'b0;
            drop_d    = drop_q;
            ok_d      = 1'b0;
            err_d     = 1'b1;
        end
`endif
    end

    // ---------------- output FIFO ----------------
    // The head word lives in out_q; the array keeps every queued entry
    // including the head, so the new head is read from rd_ptr_d, or taken
    // straight from the push when the FIFO is (or becomes) otherwise empty.
    always_comb begin : fifo_comb
        fifo_full       = (count_q == (AW + 1)'(FIFO_DEPTH));
        pop             = out_valid_q && rx.rx_ready;
        push_acc        = push && (!fifo_full || pop);
        push_drop       = push && fifo_full && !pop;
        wr_ptr_d        = wr_ptr_q + AW'(push_acc);
        rd_ptr_d        = rd_ptr_q + AW'(pop);
        count_after_pop = count_q - (AW + 1)'(pop);
        count_d         = count_after_pop + (AW + 1)'(push_acc);
        out_valid_d     = (count_d != '0);
        out_d           = out_q;
        if (count_d != '0) begin
            if (push_acc && count_after_pop == '0) out_d = {push_last, word_q};
            else                                   out_d = mem[rd_ptr_d];
        end
        overflow_d = push_drop ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);
    end

    // NOTE: the storage array carries no reset; the pointers and count are
    // reset, so stale entries are never observed.
    always_ff @(posedge OSC_50_B8A) begin : fifo_mem
        if (push_acc) mem[wr_ptr_q] <= {push_last, word_q};
    end

    always_ff @(posedge OSC_50_B8A) begin : regs
        // NOTE: non-blocking assignments throughout, so every register
        // samples its next-state value from before this edge.
        if (RESET) begin
            sync_q      <= '0;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            word_vld_q  <= 1'b0;
            word_q      <= '0;
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            csum_q      <= '0;
            drop_q      <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            overflow_q  <= 1'b0;
`ifdef HSMC_RX_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            sync_q      <= sync_d;
            strobe_q    <= sync_w[16];
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            word_vld_q  <= word_vld_d;
            word_q      <= word_d;
            state_q     <= state_d;
            rem_q       <= rem_d;
            csum_q      <= csum_d;
            drop_q      <= drop_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            overflow_q  <= overflow_d;
`ifdef HSMC_RX_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign rx.rx_data  = out_q[15:0];
    assign rx.rx_last  = out_q[16];
    assign rx.rx_valid = out_valid_q;
    assign frame_ok    = ok_q;
    assign frame_err   = err_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_hsmc_link_rx.sv
// -----------------------------------------------------------------------------
// tb_hsmc_link_rx
// Scoreboard bench for hsmc_link_rx. Frame stimulus computes the expected
// payload words and frame verdicts from the framing rules and queues them;
// an independent monitor pops and compares whenever a word is handed over
// or a frame pulse appears.
// -----------------------------------------------------------------------------
module tb_hsmc_link_rx;
    localparam int SYNC_STAGES = 2;
    localparam int SETTLE      = 2;
    localparam int FIFO_DEPTH  = 16;
    localparam int TIMEOUT     = 64;
    localparam int HOLD        = 8;
    localparam int LATENCY     = SYNC_STAGES + SETTLE + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] hsmc_rx = '0;
    logic        clr_overflow = 1'b0;
    logic        frame_ok, frame_err, overflow;

    hsmc_link_rx_if rx_if ();

    hsmc_link_rx #(
        .SYNC_STAGES(SYNC_STAGES),
        .SETTLE     (SETTLE),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .OSC_50_B8A  (clk),
        .RESET       (rst),
        .hsmc_rx     (hsmc_rx),
        .rx          (rx_if),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    always #10 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [16:0] exp_q[$];        // {last, data} expected on the stream
    bit          exp_pulse_q[$];  // 1 = frame_ok expected, 0 = frame_err
    bit          stall = 1'b0;
    bit          force_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int          idle_ready;
        logic [16:0] exp_w;
        bit          exp_ok;
        idle_ready = 0;
        rx_if.rx_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_if.rx_ready = 1'b0;
                idle_ready = 0;
            end else begin
                if (frame_ok || frame_err) begin
                    if (exp_pulse_q.size() == 0) begin
                        check("unexpected_pulse", {30'd0, frame_ok, frame_err}, 32'd0);
                    end else begin
                        exp_ok = exp_pulse_q.pop_front();
                        check("frame_pulse", {30'd0, frame_ok, frame_err},
                              exp_ok ? 32'd2 : 32'd1);
                    end
                end
                // Random backpressure, but never more than 3 idle cycles in a
                // row, which keeps the consumer faster than the link.
                if (stall)            rx_if.rx_ready = 1'b0;
                else if (force_ready) rx_if.rx_ready = 1'b1;
                else rx_if.rx_ready = ($urandom_range(0, 1) == 1) || (idle_ready >= 3);
                idle_ready = rx_if.rx_ready ? 0 : idle_ready + 1;
                if (rx_if.rx_valid && rx_if.rx_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", {31'd0, rx_if.rx_valid}, 32'd0);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("rx_word", {15'd0, rx_if.rx_last, rx_if.rx_data}, {15'd0, exp_w});
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // One link word: data and a strobe toggle, then held for HOLD cycles.
    task automatic send_word(input logic [15:0] w, input bit measure);
        @(posedge clk);
        #1;
        hsmc_rx = {~hsmc_rx[16], w};
        for (int c = 1; c <= HOLD; c++) begin
            @(posedge clk);
            #1;
            if (measure && c == LATENCY - 1) check("latency_before", {31'd0, rx_if.rx_valid}, 32'd0);
            if (measure && c == LATENCY)     check("latency_at",     {31'd0, rx_if.rx_valid}, 32'd1);
        end
    endtask

    // Full frame; expected words and verdict come from the framing rules.
    task automatic send_frame(input logic [15:0] pl[$], input logic [15:0] csum_delta,
                              input bit measure);
        logic [15:0] sum = '0;
        bit          dropped = 1'b0;
        send_word({8'hA5, 8'(pl.size())}, 1'b0);
        foreach (pl[i]) begin
            if (stall && exp_q.size() >= FIFO_DEPTH) dropped = 1'b1;
            else exp_q.push_back({(i == pl.size() - 1), pl[i]});
            sum += pl[i];
            send_word(pl[i], measure && (i == 0));
        end
        exp_pulse_q.push_back(!dropped && (csum_delta == 16'd0));
        send_word(sum + csum_delta, 1'b0);
    endtask

    task automatic send_bad_header(input logic [15:0] w);
        exp_pulse_q.push_back(1'b0);
        send_word(w, 1'b0);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || exp_pulse_q.size() != 0) && t < 4000) begin
            @(posedge clk);
            t++;
        end
        check("drain_outstanding", exp_q.size() + exp_pulse_q.size(), 32'd0);
    endtask

    task automatic random_frame(input int len, input bit corrupt);
        logic [15:0] pl[$];
        for (int i = 0; i < len; i++) pl.push_back(16'($urandom));
        send_frame(pl, corrupt ? 16'($urandom_range(1, 65535)) : 16'd0, 1'b0);
    endtask

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [15:0] pl[$];
        logic [15:0] w;
        int          cyc;

        repeat (4) @(posedge clk);
        #1;
        check("reset_valid",     {31'd0, rx_if.rx_valid}, 32'd0);
        check("reset_data",      {16'd0, rx_if.rx_data},  32'd0);
        check("reset_last",      {31'd0, rx_if.rx_last},  32'd0);
        check("reset_frame_ok",  {31'd0, frame_ok},       32'd0);
        check("reset_frame_err", {31'd0, frame_err},      32'd0);
        check("reset_overflow",  {31'd0, overflow},       32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Good frame with latency measured on the first payload word.
        force_ready = 1'b1;
        pl = {16'h0001, 16'h0002, 16'h0003};
        send_frame(pl, 16'd0, 1'b1);
        drain();
        // Same frame, checksum 0x0007.
        send_frame(pl, 16'd1, 1'b0);
        drain();

        // Bad headers.
        send_bad_header(16'h5A03);
        send_bad_header(16'hA500);
        drain();
        #1;
        check("bad_header_fifo_empty", {31'd0, rx_if.rx_valid}, 32'd0);

        // Overflow: 20-word frame into a stalled 16-entry FIFO.
        stall = 1'b1;
        random_frame(20, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("overflow_set",    {31'd0, overflow},       32'd1);
        check("overflow_queued", {31'd0, rx_if.rx_valid}, 32'd1);
        clr_overflow = 1'b1;
        @(posedge clk);
        #1;
        clr_overflow = 1'b0;
        check("overflow_cleared", {31'd0, overflow}, 32'd0);
        stall = 1'b0;
        drain();

        // Randomised traffic with random backpressure.
        force_ready = 1'b0;
        for (int f = 0; f < 20; f++) begin
            if ($urandom_range(0, 7) == 0) begin
                w = 16'($urandom);
                if (w[15:8] == 8'hA5 && w[7:0] != 8'd0) w[15:8] = 8'h00;
                send_bad_header(w);
            end else begin
                random_frame($urandom_range(1, 12), $urandom_range(0, 3) == 0);
            end
        end
        drain();

`ifdef HSMC_RX_TIMEOUT_EN
        // Header for 4 words, only 2 sent, then silence.
        force_ready = 1'b1;
        exp_pulse_q.push_back(1'b0);
        send_word(16'hA504, 1'b0);
        for (int i = 0; i < 2; i++) begin
            w = 16'($urandom);
            exp_q.push_back({1'b0, w});
            send_word(w, 1'b0);
        end
        cyc = HOLD;
        while (frame_err !== 1'b1 && cyc < TIMEOUT + 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("timeout_latency_in_window",
              {31'd0, (cyc >= TIMEOUT && cyc <= TIMEOUT + SYNC_STAGES + 4)}, 32'd1);
        drain();
        random_frame(3, 1'b0);
        drain();
        force_ready = 1'b0;
`endif

        // Reset mid-frame with 3 words queued; strobe must rest at 0 first
        // so the cleared synchroniser sees no spurious event afterwards.
        if (hsmc_rx[16]) begin
            send_bad_header(16'h0000);
            drain();
        end
        stall = 1'b1;
        send_word(16'hA505, 1'b0);
        for (int i = 0; i < 3; i++) send_word(16'($urandom), 1'b0);
        check("pre_reset_queued", {31'd0, rx_if.rx_valid}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_valid",     {31'd0, rx_if.rx_valid}, 32'd0);
        check("midreset_frame_ok",  {31'd0, frame_ok},       32'd0);
        check("midreset_frame_err", {31'd0, frame_err},      32'd0);
        rst = 1'b0;
        stall = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("post_reset_idle", {29'd0, rx_if.rx_valid, frame_ok, frame_err}, 32'd0);
        random_frame(5, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
